bb_stream_buffer: RTL and testbench

//  Parametrised successor to the baseband pass-through stage: registered, elastic Wishbone-stream buffer between RX baseband blocks.

---
 rtl/bb_pkg.sv | 40 ++++
 rtl/bb_fifo_mem.sv | 39 +++
 rtl/bb_stream_buffer.sv | 152 +++++++++++++++
 tb/tb_bb_stream_buffer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bb_pkg.sv
// Shared definitions for the baseband stream blocks.
// Holds the default sample width, the read-path mode encodings, a saturating
// negate helper and slice macros for the {Im,Re} sample packing.

`ifndef BB_PKG_MACROS
`define BB_PKG_MACROS
// Re lives in the lower half of a packed sample, Im in the upper half.
// Both expect DAT_W to be visible at the point of use and x to be a variable.
`define BB_RE(x) (x[DAT_W-1:0])
`define BB_IM(x) (x[2*DAT_W-1:DAT_W])
`endif

package bb_pkg;

    localparam int BB_DAT_W = 16;
    // Widest component the sat_neg helper supports.
    localparam int BB_MAX_W = 32;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_SWAP = 2'b01;
    localparam logic [1:0] MODE_CONJ = 2'b10;

    // Two's-complement negate of the low w bits of x. The most negative value
    // has no positive counterpart, so it saturates to the most positive one.
    function automatic logic [BB_MAX_W-1:0] sat_neg(input logic [BB_MAX_W-1:0] x,
                                                    input int w);
        logic [BB_MAX_W-1:0] mask;
        logic [BB_MAX_W-1:0] min_v;
        logic [BB_MAX_W-1:0] xm;
        mask  = (BB_MAX_W'(1) << w) - BB_MAX_W'(1);
        min_v = BB_MAX_W'(1) << (w - 1);
        xm    = x & mask;
        if (xm == min_v) begin
            sat_neg = min_v - BB_MAX_W'(1);
        end else begin
            sat_neg = (~xm + BB_MAX_W'(1)) & mask;
        end
    endfunction

endpackage

// File: rtl/bb_fifo_mem.sv
// Storage array for bb_stream_buffer: 2**AW words of W bits.
// Synchronous write, asynchronous read. The top bit of each word is the
// frame LAST flag; set_last_i raises it on an already-written word without
// touching the payload.
// Ports:
//   clk_i       write clock
//   we_i        write full word wdata_i at waddr_i
//   set_last_i  set bit W-1 of word waddr_i (ignored when we_i=1)
//   waddr_i     write / set-last address
//   wdata_i     write data
//   raddr_i     read address
//   rdata_o     read data (combinational)

module bb_fifo_mem #(
    parameter int W  = 33,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          set_last_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end else if (set_last_i) begin
            mem_q[waddr_i][W-1] <= 1'b1;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bb_stream_buffer.sv
// Elastic Wishbone-stream buffer between RX baseband blocks.
// Samples {Im,Re} are queued in a first-word-fall-through FIFO; frame
// boundaries (CYC) travel with the data as a per-entry LAST bit. The read
// path optionally swaps or conjugates the head sample.
// Ports:
//   CLK_I, RST_I            clock, async active-low reset
//   DAT_I/WE_I/STB_I/CYC_I  upstream sample, strobes, frame
//   ACK_O                   upstream sample accepted (combinational)
//   DAT_O/CYC_O/STB_O/WE_O  downstream head sample and strobes
//   ACK_I                   downstream takes DAT_O this cycle
//   MODE_I                  00 pass, 01 swap, 10 conjugate, 11 pass
//   LEVEL_O                 entries stored
//   OVF_O/UNF_O             sticky overflow/underflow, cleared by CLR_I
// Handshake: upstream transfer happens on a cycle where STB_I&CYC_I&WE_I and
// ACK_O are all high; downstream transfer on a cycle where STB_O&ACK_I.

module bb_stream_buffer import bb_pkg::*; #(
    parameter int DAT_W = BB_DAT_W,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic [2*DAT_W-1:0] DAT_I,
    input  logic               WE_I,
    input  logic               STB_I,
    input  logic               CYC_I,
    output logic               ACK_O,
    output logic [2*DAT_W-1:0] DAT_O,
    output logic               CYC_O,
    output logic               STB_O,
    output logic               WE_O,
    input  logic               ACK_I,
    input  logic [1:0]         MODE_I,
    output logic [CNT_W-1:0]   LEVEL_O,
    output logic               OVF_O,
    output logic               UNF_O,
    input  logic               CLR_I
);

    localparam int AW = CNT_W - 1;
    localparam int MW = 2 * DAT_W + 1;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   level_q, level_d;
    logic               stb_q, stb_d;
    logic               cyc_q, cyc_d;
    logic               cyc_in_q;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic               full, empty, attempt, push, pop;
    logic               cyc_fall, fall_drains, set_last, frame_end;
    logic [AW-1:0]      mem_addr;
    logic [MW-1:0]      head;
    logic [2*DAT_W-1:0] head_dat;
    logic [DAT_W-1:0]   re, im, im_neg;

    assign full    = (level_q == CNT_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign attempt = STB_I & CYC_I & WE_I;
    // Gated by reset so nothing is acknowledged while the buffer is held clear.
    assign push    = RST_I & attempt & ~full;
    assign pop     = stb_q & ACK_I;

    // Frame end seen on the input. push is always 0 in that cycle (CYC_I=0),
    // so the write port is free to mark the newest entry as LAST.
    assign cyc_fall    = cyc_in_q & ~CYC_I;
    // Nothing left to tag once this cycle's pop is done: end the frame directly.
    assign fall_drains = cyc_fall & (empty | ((level_q == CNT_W'(1)) & pop));
    assign set_last    = cyc_fall & ~fall_drains;
    assign frame_end   = (pop & head[MW-1]) | fall_drains;
    assign mem_addr    = push ? wr_ptr_q : (wr_ptr_q - AW'(1));

    bb_fifo_mem #(
        .W  (MW),
        .AW (AW)
    ) u_mem (
        .clk_i      (CLK_I),
        .we_i       (push),
        .set_last_i (set_last),
        .waddr_i    (mem_addr),
        .wdata_i    ({1'b0, DAT_I}),
        .raddr_i    (rd_ptr_q),
        .rdata_o    (head)
    );

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + CNT_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - CNT_W'(1);
        end
        stb_d = (level_d != '0);
        // A first push of a new frame in the same cycle keeps CYC_O high.
        cyc_d = push | (cyc_q & ~frame_end);
        ovf_d = (attempt & full)  ? 1'b1 : (CLR_I ? 1'b0 : ovf_q);
        unf_d = (ACK_I & ~stb_q) ? 1'b1 : (CLR_I ? 1'b0 : unf_q);
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            cyc_in_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            cyc_in_q <= CYC_I;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Read-path transform; the stored sample is never modified.
    assign head_dat = head[2*DAT_W-1:0];
    assign re       = `BB_RE(head_dat);
    assign im       = `BB_IM(head_dat);
    assign im_neg   = DAT_W'(sat_neg(BB_MAX_W'(im), DAT_W));

    always_comb begin
        DAT_O = '0;
        if (stb_q) begin
            case (MODE_I)
                MODE_SWAP: DAT_O = {re, im};
                MODE_CONJ: DAT_O = {im_neg, re};
                default:   DAT_O = {im, re};
            endcase
        end
    end

    assign ACK_O   = push;
    assign STB_O   = stb_q;
    assign WE_O    = stb_q;
    assign CYC_O   = cyc_q;
    assign LEVEL_O = level_q;
    assign OVF_O   = ovf_q;
    assign UNF_O   = unf_q;

endmodule

// File: tb/tb_bb_stream_buffer.sv
// Directed bench for bb_stream_buffer: ordering and latency, full/overflow,
// frame-end propagation, read-path modes, full with simultaneous pop,
// underflow, sticky flag clearing and mid-frame reset.

module tb_bb_stream_buffer;

    localparam int DAT_W = 16;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;
    localparam int W     = 2 * DAT_W;

    logic             CLK_I = 1'b0;
    logic             RST_I;
    logic [W-1:0]     DAT_I;
    logic             WE_I;
    logic             STB_I;
    logic             CYC_I;
    logic             ACK_O;
    logic [W-1:0]     DAT_O;
    logic             CYC_O;
    logic             STB_O;
    logic             WE_O;
    logic             ACK_I;
    logic [1:0]       MODE_I;
    logic [CNT_W-1:0] LEVEL_O;
    logic             OVF_O;
    logic             UNF_O;
    logic             CLR_I;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] t1 [4];

    always #5 CLK_I = ~CLK_I;

    bb_stream_buffer #(
        .DAT_W (DAT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .DAT_I   (DAT_I),
        .WE_I    (WE_I),
        .STB_I   (STB_I),
        .CYC_I   (CYC_I),
        .ACK_O   (ACK_O),
        .DAT_O   (DAT_O),
        .CYC_O   (CYC_O),
        .STB_O   (STB_O),
        .WE_O    (WE_O),
        .ACK_I   (ACK_I),
        .MODE_I  (MODE_I),
        .LEVEL_O (LEVEL_O),
        .OVF_O   (OVF_O),
        .UNF_O   (UNF_O),
        .CLR_I   (CLR_I)
    );

    // Inputs change 2 time units after the rising edge; outputs are sampled
    // one unit later, well away from either clock edge.
    task automatic tick();
        @(posedge CLK_I);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
        checks++;
        assert (obs === exp_val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_val);
        end
    endtask

    initial begin
        t1[0] = 32'h0001_0002;
        t1[1] = 32'h0002_0003;
        t1[2] = 32'h0003_0004;
        t1[3] = 32'h0004_0005;

        // ---------------- reset, upstream already driving ----------------
        RST_I  = 1'b0;
        DAT_I  = 32'h1111_2222;
        WE_I   = 1'b1;
        STB_I  = 1'b1;
        CYC_I  = 1'b1;
        ACK_I  = 1'b0;
        MODE_I = 2'b00;
        CLR_I  = 1'b0;
        tick();
        settle();
        chk("rst_ack", ACK_O, 0);
        chk("rst_stb", STB_O, 0);
        chk("rst_cyc", CYC_O, 0);
        chk("rst_we", WE_O, 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_level", LEVEL_O, 0);
        chk("rst_ovf", OVF_O, 0);
        chk("rst_unf", UNF_O, 0);
        tick();
        STB_I = 1'b0;
        CYC_I = 1'b0;
        WE_I  = 1'b0;
        RST_I = 1'b1;
        tick();

        // ---------------- 1: ordering and 1-cycle latency ----------------
        CYC_I = 1'b1;
        WE_I  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            STB_I = 1'b1;
            DAT_I = t1[i];
            ACK_I = (i > 0);
            settle();
            chk("t1_ack", ACK_O, 1);
            if (i > 0) begin
                chk("t1_dat", DAT_O, t1[i-1]);
                chk("t1_level", LEVEL_O, 1);
            end
            tick();
        end
        // Frame ends in the same cycle its only buffered entry is popped.
        STB_I = 1'b0;
        CYC_I = 1'b0;
        settle();
        chk("t1_dat_last", DAT_O, t1[3]);
        chk("t1_cyc_hold", CYC_O, 1);
        chk("t1_level_last", LEVEL_O, 1);
        tick();
        ACK_I = 1'b0;
        settle();
        chk("t1_stb_empty", STB_O, 0);
        chk("t1_cyc_drop", CYC_O, 0);
        chk("t1_level_empty", LEVEL_O, 0);
        chk("t1_dat_empty", DAT_O, 0);
        chk("t1_unf", UNF_O, 0);

        // ---------------- 2: fill, overflow, drain, clear ----------------
        CYC_I = 1'b1;
        WE_I  = 1'b1;
        STB_I = 1'b1;
        ACK_I = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            DAT_I = 32'h0100_0000 + i;
            exp_q.push_back(DAT_I);
            settle();
            chk("t2_ack", ACK_O, 1);
            tick();
        end
        DAT_I = 32'hDEAD_BEEF;
        settle();
        chk("t2_ack_full", ACK_O, 0);
        chk("t2_level_full", LEVEL_O, 16);
        chk("t2_ovf_before", OVF_O, 0);
        tick();
        STB_I = 1'b0;
        settle();
        chk("t2_ovf_set", OVF_O, 1);
        chk("t2_level_held", LEVEL_O, 16);
        ACK_I = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            settle();
            chk("t2_stb", STB_O, 1);
            exp_v = exp_q.pop_front();
            chk("t2_dat", DAT_O, exp_v);
            tick();
        end
        ACK_I = 1'b0;
        settle();
        chk("t2_stb_drained", STB_O, 0);
        chk("t2_level_drained", LEVEL_O, 0);
        chk("t2_cyc_open", CYC_O, 1);
        chk("t2_ovf_sticky", OVF_O, 1);
        CLR_I = 1'b1;
        tick();
        CLR_I = 1'b0;
        settle();
        chk("t2_ovf_clr", OVF_O, 0);
        CYC_I = 1'b0;
        tick();
        settle();
        chk("t2_cyc_drop_empty", CYC_O, 0);
        tick();

        // ---------------- 3: frame end with two entries buffered ----------------
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        ACK_I = 1'b0;
        DAT_I = 32'h0A00_0A01;
        tick();
        DAT_I = 32'h0A02_0A03;
        ACK_I = 1'b1;
        tick();
        DAT_I = 32'h0A04_0A05;
        ACK_I = 1'b0;
        tick();
        STB_I = 1'b0;
        CYC_I = 1'b0;
        settle();
        chk("t3_level_at_fall", LEVEL_O, 2);
        chk("t3_cyc_at_fall", CYC_O, 1);
        tick();
        ACK_I = 1'b1;
        settle();
        chk("t3_dat_mid", DAT_O, 32'h0A02_0A03);
        chk("t3_cyc_mid", CYC_O, 1);
        tick();
        settle();
        chk("t3_dat_last", DAT_O, 32'h0A04_0A05);
        chk("t3_level_last", LEVEL_O, 1);
        chk("t3_cyc_last", CYC_O, 1);
        tick();
        ACK_I = 1'b0;
        settle();
        chk("t3_cyc_drop", CYC_O, 0);
        chk("t3_stb_empty", STB_O, 0);

        // ---------------- 4: read-path modes ----------------
        CYC_I = 1'b1;
        STB_I = 1'b1;
        DAT_I = 32'h8000_1234;
        tick();
        DAT_I = 32'h0003_0005;
        tick();
        STB_I  = 1'b0;
        MODE_I = 2'b10;
        settle();
        chk("t4_conj_sat", DAT_O, 32'h7FFF_1234);
        MODE_I = 2'b01;
        settle();
        chk("t4_swap", DAT_O, 32'h1234_8000);
        MODE_I = 2'b11;
        settle();
        chk("t4_reserved", DAT_O, 32'h8000_1234);
        MODE_I = 2'b00;
        ACK_I  = 1'b1;
        settle();
        chk("t4_pass", DAT_O, 32'h8000_1234);
        tick();
        ACK_I  = 1'b0;
        MODE_I = 2'b10;
        settle();
        chk("t4_conj", DAT_O, 32'hFFFD_0005);
        MODE_I = 2'b01;
        settle();
        chk("t4_swap2", DAT_O, 32'h0005_0003);
        ACK_I = 1'b1;
        tick();
        ACK_I  = 1'b0;
        CYC_I  = 1'b0;
        MODE_I = 2'b00;
        settle();
        chk("t4_level_empty", LEVEL_O, 0);
        tick();
        settle();
        chk("t4_cyc_drop", CYC_O, 0);

        // ---------------- 5: full with push and pop together; underflow ----------------
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        ACK_I = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            DAT_I = 32'h0200_0000 + i;
            if (i > 0) exp_q.push_back(DAT_I);
            tick();
        end
        DAT_I = 32'hBEEF_BEEF;
        ACK_I = 1'b1;
        settle();
        chk("t5_ack_full_pop", ACK_O, 0);
        chk("t5_level_full", LEVEL_O, 16);
        tick();
        STB_I = 1'b0;
        ACK_I = 1'b0;
        settle();
        chk("t5_level_15", LEVEL_O, 15);
        chk("t5_ovf", OVF_O, 1);
        ACK_I = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            settle();
            exp_v = exp_q.pop_front();
            chk("t5_dat", DAT_O, exp_v);
            tick();
        end
        settle();
        chk("t5_stb_empty", STB_O, 0);
        chk("t5_unf_before", UNF_O, 0);
        tick();
        ACK_I = 1'b0;
        settle();
        chk("t5_unf_set", UNF_O, 1);
        tick();
        settle();
        chk("t5_unf_sticky", UNF_O, 1);
        CLR_I = 1'b1;
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        settle();
        chk("t5_unf_set_wins", UNF_O, 1);
        chk("t5_ovf_clr", OVF_O, 0);
        tick();
        CLR_I = 1'b0;
        settle();
        chk("t5_unf_clr", UNF_O, 0);
        CYC_I = 1'b0;
        tick();

        // ---------------- 6: reset mid-frame ----------------
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        ACK_I = 1'b0;
        for (int i = 0; i < 5; i++) begin
            DAT_I = 32'h0300_0000 + i;
            tick();
        end
        STB_I = 1'b0;
        settle();
        chk("t6_level_5", LEVEL_O, 5);
        chk("t6_cyc_before", CYC_O, 1);
        RST_I = 1'b0;
        STB_I = 1'b1;
        settle();
        chk("t6_stb_rst", STB_O, 0);
        chk("t6_cyc_rst", CYC_O, 0);
        chk("t6_we_rst", WE_O, 0);
        chk("t6_level_rst", LEVEL_O, 0);
        chk("t6_dat_rst", DAT_O, 0);
        chk("t6_ack_rst", ACK_O, 0);
        tick();
        RST_I = 1'b1;
        STB_I = 1'b0;
        settle();
        chk("t6_stb_rel", STB_O, 0);
        chk("t6_cyc_rel", CYC_O, 0);
        tick();
        settle();
        chk("t6_stb_idle", STB_O, 0);
        chk("t6_cyc_idle", CYC_O, 0);
        chk("t6_level_idle", LEVEL_O, 0);
        WE_I  = 1'b0;
        STB_I = 1'b1;
        settle();
        chk("t6_ack_no_we", ACK_O, 0);
        tick();
        settle();
        chk("t6_level_no_we", LEVEL_O, 0);
        WE_I  = 1'b1;
        DAT_I = 32'h0C0D_0E0F;
        settle();
        chk("t6_ack_new", ACK_O, 1);
        tick();
        STB_I = 1'b0;
        settle();
        chk("t6_stb_new", STB_O, 1);
        chk("t6_cyc_new", CYC_O, 1);
        chk("t6_dat_new", DAT_O, 32'h0C0D_0E0F);
        ACK_I = 1'b1;
        CYC_I = 1'b0;
        tick();
        ACK_I = 1'b0;
        settle();
        chk("t6_stb_end", STB_O, 0);
        chk("t6_cyc_end", CYC_O, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
